// File: rtl/qkd_collapse_arbiter.sv
// qkd_collapse_arbiter: round-robin arbiter and sequencer for a bank of
// read-once collapse registers. Provisions every slot, serialises reads
// (one read strobe per grant), tracks consumed slots and answers the
// winning requester with a value and a status code.
// Optional feature: define QKD_ARB_LOCKOUT_EN to lock out requesters after
// MAX_FAIL basis failures.
module qkd_collapse_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_W    = 4,
  parameter int MAX_FAIL  = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        prov_start,
  output logic                        prov_busy,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*SLOT_W-1:0]   req_slot,
  input  logic [NUM_REQ*2-1:0]        req_basis,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [7:0]                  rsp_data,
  output logic [1:0]                  rsp_status,
  output logic [NUM_SLOTS-1:0]        reg_init,
  output logic [NUM_SLOTS-1:0]        reg_read,
  output logic [1:0]                  reg_basis,
  input  logic [NUM_SLOTS*8-1:0]      reg_value,
  input  logic [NUM_SLOTS-1:0]        reg_oe,
  output logic [NUM_SLOTS-1:0]        slot_used
);

  localparam int REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  localparam logic [1:0] STS_OK     = 2'b00;
  localparam logic [1:0] STS_FAIL   = 2'b01;
  localparam logic [1:0] STS_USED   = 2'b10;
  localparam logic [1:0] STS_LOCKED = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PROV = 3'd1,
    ST_ARB  = 3'd2,
    ST_READ = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  state_t                 state_r, state_nx_s;
  logic [REQ_W-1:0]       rr_ptr_r, winner_r, winner_s;
  logic [CNT_W-1:0]       prov_cnt_r;
  logic [NUM_SLOTS-1:0]   slot_used_r, reg_init_r, reg_read_r;
  logic [1:0]             reg_basis_r, rsp_status_r, win_basis_s;
  logic [NUM_REQ-1:0]     rsp_valid_r, req_ready_s;
  logic [7:0]             rsp_data_r, rd_value_s;
  logic [SLOT_W-1:0]      win_slot_s;
  logic                   any_req_s, slot_bad_s, locked_s, rd_oe_s;

  // First requester with valid at or after ptr, wrapping around.
  function automatic logic [REQ_W-1:0] pick_winner(input logic [NUM_REQ-1:0] valid,
                                                   input logic [REQ_W-1:0]   ptr);
    logic [REQ_W-1:0] w;
    logic             found;
    logic             hit;
    int               idx;
    w     = {REQ_W{1'b0}};
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx   = (int'(ptr) + i) % NUM_REQ;
      hit   = !found && valid[idx];
      w     = hit ? REQ_W'(idx) : w;
      found = found | hit;
    end
    return w;
  endfunction

  // A slot index outside the bank counts as unavailable.
  function automatic logic slot_unavailable(input logic [SLOT_W-1:0]    s,
                                            input logic [NUM_SLOTS-1:0] used);
    logic r;
    r = 1'b1;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      r = (int'(s) == i) ? used[i] : r;
    end
    return r;
  endfunction

  function automatic logic [NUM_SLOTS-1:0] slot_onehot(input logic [SLOT_W-1:0] s);
    logic [NUM_SLOTS-1:0] v;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      v[i] = (int'(s) == i);
    end
    return v;
  endfunction

  function automatic logic [NUM_REQ-1:0] req_onehot(input logic [REQ_W-1:0] w);
    logic [NUM_REQ-1:0] v;
    for (int i = 0; i < NUM_REQ; i++) begin
      v[i] = (int'(w) == i);
    end
    return v;
  endfunction

  assign any_req_s   = |req_valid;
  assign winner_s    = pick_winner(req_valid, rr_ptr_r);
  assign win_slot_s  = req_slot[int'(winner_s)*SLOT_W +: SLOT_W];
  assign win_basis_s = req_basis[int'(winner_s)*2 +: 2];
  assign slot_bad_s  = slot_unavailable(win_slot_s, slot_used_r);

  // Select the value/oe of the slot being read; reg_read_r is one-hot in READ.
  always_comb begin
    rd_value_s = 8'h00;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      rd_value_s = rd_value_s | (reg_value[i*8 +: 8] & {8{reg_read_r[i]}});
    end
    rd_oe_s = |(reg_oe & reg_read_r);
  end

`ifdef QKD_ARB_LOCKOUT_EN
  logic [1:0] fail_cnt_r [NUM_REQ];

  // Per-requester basis-failure counters, saturating at MAX_FAIL; only reset_n clears them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) fail_cnt_r[i] <= 2'd0;
    end else if (state_r == ST_READ && !rd_oe_s && fail_cnt_r[winner_r] != 2'(MAX_FAIL)) begin
      fail_cnt_r[winner_r] <= fail_cnt_r[winner_r] + 2'd1;
    end
  end

  assign locked_s = (fail_cnt_r[winner_s] == 2'(MAX_FAIL));
`else
  assign locked_s = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= state_nx_s;
  end

  // Next-state logic and the grant pulse (grant must reflect the live request).
  always_comb begin
    state_nx_s  = state_r;
    req_ready_s = {NUM_REQ{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (prov_start)     state_nx_s = ST_PROV;
        else if (any_req_s) state_nx_s = ST_ARB;
        else                state_nx_s = ST_IDLE;
      end
      ST_PROV: begin
        if (prov_cnt_r == CNT_W'(NUM_SLOTS-1)) state_nx_s = ST_IDLE;
        else                                   state_nx_s = ST_PROV;
      end
      ST_ARB: begin
        if (!any_req_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          req_ready_s[winner_s] = 1'b1;
          if (locked_s || slot_bad_s) state_nx_s = ST_RESP;
          else                        state_nx_s = ST_READ;
        end
      end
      ST_READ: state_nx_s = ST_RESP;
      ST_RESP: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Datapath: provisioning walk, read strobe, response capture, slot map, rr pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_r     <= {REQ_W{1'b0}};
      winner_r     <= {REQ_W{1'b0}};
      prov_cnt_r   <= {CNT_W{1'b0}};
      slot_used_r  <= {NUM_SLOTS{1'b1}};
      reg_init_r   <= {NUM_SLOTS{1'b0}};
      reg_read_r   <= {NUM_SLOTS{1'b0}};
      reg_basis_r  <= 2'b00;
      rsp_valid_r  <= {NUM_REQ{1'b0}};
      rsp_data_r   <= 8'h00;
      rsp_status_r <= 2'b00;
    end else begin
      reg_init_r   <= {NUM_SLOTS{1'b0}};
      reg_read_r   <= {NUM_SLOTS{1'b0}};
      reg_basis_r  <= 2'b00;
      rsp_valid_r  <= {NUM_REQ{1'b0}};
      rsp_data_r   <= 8'h00;
      rsp_status_r <= 2'b00;
      case (state_r)
        ST_IDLE: begin
          if (prov_start) begin
            prov_cnt_r <= {CNT_W{1'b0}};
            reg_init_r <= {{(NUM_SLOTS-1){1'b0}}, 1'b1};
          end
        end
        ST_PROV: begin
          // reg_init_r is the one-hot of the slot being initialised this cycle.
          slot_used_r <= slot_used_r & ~reg_init_r;
          if (prov_cnt_r != CNT_W'(NUM_SLOTS-1)) begin
            prov_cnt_r <= prov_cnt_r + CNT_W'(1);
            reg_init_r <= {reg_init_r[NUM_SLOTS-2:0], 1'b0};
          end else begin
            prov_cnt_r <= {CNT_W{1'b0}};
          end
        end
        ST_ARB: begin
          if (any_req_s) begin
            winner_r <= winner_s;
            if (locked_s) begin
              rsp_valid_r  <= req_onehot(winner_s);
              rsp_status_r <= STS_LOCKED;
            end else if (slot_bad_s) begin
              rsp_valid_r  <= req_onehot(winner_s);
              rsp_status_r <= STS_USED;
            end else begin
              reg_read_r  <= slot_onehot(win_slot_s);
              reg_basis_r <= win_basis_s;
            end
          end
        end
        ST_READ: begin
          // The read collapses the slot whatever the basis outcome.
          slot_used_r <= slot_used_r | reg_read_r;
          rsp_valid_r <= req_onehot(winner_r);
          if (rd_oe_s) begin
            rsp_data_r   <= rd_value_s;
            rsp_status_r <= STS_OK;
          end else begin
            rsp_data_r   <= 8'h00;
            rsp_status_r <= STS_FAIL;
          end
        end
        ST_RESP: begin
          rr_ptr_r <= (int'(winner_r) == NUM_REQ-1) ? {REQ_W{1'b0}} : winner_r + REQ_W'(1);
        end
        default: begin
          rr_ptr_r <= rr_ptr_r;
        end
      endcase
    end
  end

  assign prov_busy  = (state_r == ST_PROV);
  assign req_ready  = req_ready_s;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_data   = rsp_data_r;
  assign rsp_status = rsp_status_r;
  assign reg_init   = reg_init_r;
  assign reg_read   = reg_read_r;
  assign reg_basis  = reg_basis_r;
  assign slot_used  = slot_used_r;

endmodule

// File: doc/qkd_collapse_arbiter.md
Name: qkd_collapse_arbiter

Overview:
- Controller and round-robin arbiter that shares a bank of NUM_SLOTS read-once collapse registers between NUM_REQ requesters.
- Sequences provisioning, which pulses init to every slot.
- Serialises read accesses, one strobe per grant, and tracks which slots have been consumed.
- Returns the value plus a status code to the winning requester. Sits between the requester fabric and the collapse-register bank.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- NUM_SLOTS, 8, number of collapse registers (2..16).
- SLOT_W, 4, slot index width; must be at least clog2(NUM_SLOTS).
- MAX_FAIL, 3, basis failures before requester lockout (1..3); used only with the optional feature.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- prov_start  in  1  pulse: provision all slots.
- prov_busy  out  1  high while provisioning.
- req_valid  in  NUM_REQ  per-requester request; held until req_ready.
- req_slot  in  NUM_REQ*SLOT_W  packed target slot per requester.
- req_basis  in  NUM_REQ*2  packed basis guess per requester.
- req_ready  out  NUM_REQ  one-hot 1-cycle grant/accept pulse.
- rsp_valid  out  NUM_REQ  one-hot 1-cycle response pulse.
- rsp_data  out  8  response value; valid with rsp_valid.
- rsp_status  out  2  00 OK, 01 BASIS_FAIL, 10 USED, 11 LOCKED.
- reg_init  out  NUM_SLOTS  per-slot init strobe.
- reg_read  out  NUM_SLOTS  per-slot read strobe.
- reg_basis  out  2  basis guess to the bank; shared by all slots.
- reg_value  in  NUM_SLOTS*8  packed value_out from slots.
- reg_oe  in  NUM_SLOTS  output_enable from slots.
- slot_used  out  NUM_SLOTS  consumed/unprovisioned map.

Behaviour:
- Reset values:
  - All outputs 0, except slot_used, which resets to all ones: no slot is readable until provisioned.
  - FSM resets to IDLE, rr_ptr to 0, fail counters to 0.
- FSM states: IDLE, PROV, ARB, READ, RESP.
- IDLE:
  - If prov_start is high, go to PROV. Provisioning has priority over simultaneous req_valid.
  - Otherwise, if any req_valid is high, go to ARB.
  - prov_start outside IDLE is ignored.
- PROV:
  - Counter runs 0..NUM_SLOTS-1, one slot per cycle.
  - Each cycle: reg_init[cnt]=1 and slot_used[cnt] is cleared.
  - After the last slot, go to IDLE. PROV lasts exactly NUM_SLOTS cycles.
  - prov_busy is high for the whole of PROV; req_ready is 0.
- ARB:
  - Winner = first requester with req_valid, scanning from rr_ptr upward with wrap.
  - req_ready[winner]=1 for this cycle; slot and basis are captured into registers.
  - If no req_valid remains, go to IDLE.
  - Winner locked: go to RESP with LOCKED.
  - Else slot ≥ NUM_SLOTS or slot_used[slot]=1: go to RESP with USED, rsp_data=0; no read is issued.
  - Else go to READ.
- READ:
  - Exactly one cycle: reg_read[slot]=1 and reg_basis=captured basis.
  - reg_value and reg_oe are sampled on the closing edge.
  - slot_used[slot] is set unconditionally, because a read collapses the slot whether or not the basis matches.
  - reg_oe=1: status OK, rsp_data = the slot's reg_value.
  - reg_oe=0: status BASIS_FAIL, rsp_data=0; the obfuscated value is never forwarded.
  - Go to RESP.
- RESP:
  - rsp_valid[winner]=1 for 1 cycle with rsp_data/rsp_status.
  - rr_ptr = (winner+1) mod NUM_REQ.
  - Go to IDLE.
- Latency:
  - Read path: req_valid seen in IDLE → rsp_valid 4 cycles later (IDLE, ARB, READ, RESP).
  - USED/LOCKED path: 3 cycles.
- Outside READ, reg_basis=0.
- At most one reg_read bit is high in any cycle, and never in the same cycle as any reg_init bit.
- A requester dropping req_valid before req_ready is not granted; no side effects.
- Asserting reset_n low mid-operation:
  - Immediately clears all strobes and responses; no partial pulse completes.
  - slot_used returns to all ones, so re-provisioning is required.

Optional Feature:
- Macro: QKD_ARB_LOCKOUT_EN.
- Defined:
  - Each requester has a 2-bit failure counter, incremented on BASIS_FAIL and saturating at MAX_FAIL.
  - A requester whose counter equals MAX_FAIL is locked: granted but answered LOCKED, with no read strobe and slot_used unchanged.
  - Counters are cleared only by reset_n; provisioning does not clear them.
- Undefined:
  - No counters; status 11 is never produced.
  - A failed requester may retry freely.

Test Plan:
- Provision: reset, then prov_start → prov_busy high for 8 cycles; reg_init walks slots 0..7 one-hot; slot_used=0x00 afterwards.
- Good read: after provisioning, requester 1 reads slot 3 with basis matching, reg_oe=1, reg_value=0x5C → exactly one reg_read[3] pulse; rsp_valid=0b0010, rsp_data=0x5C, status 00; slot_used=0x08.
- Re-read and basis fail:
  - Requester 0 reads slot 3 again → status 10, data 0x00, no reg_read pulse.
  - Requester 0 reads slot 4 with wrong basis (reg_oe=0) → status 01, data 0x00, slot_used bit 4 set.
- Fairness: all four requesters hold req_valid from rr_ptr=0 → grants in order 0,1,2,3, each followed by its RESP before the next ARB.
- Reset and collisions:
  - Without provisioning after reset, any read → USED.
  - prov_start in the same cycle as req_valid → PROV first, then the request is served.
- Lockout (macro defined, MAX_FAIL=3): three BASIS_FAILs from requester 2 → fourth request gets status 11 with no reg_read pulse. Macro undefined → fourth request issues a read normally.
